// File: rtl/conv2_seq_if.sv
// conv2_seq_if: control, source-read and output-pixel bundle of the conv2
// sequencer. master = the sequencer, slave = the surrounding datapath/host.
interface conv2_seq_if;
  logic       start;
  logic       abort;
  logic       hold;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic       layer_valid_in;
  logic       valid_out_conv2;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, abort, hold, valid_out_conv2,
    output rd_en, rd_addr, layer_valid_in, out_row, out_col, out_last,
           busy, done, err
  );

  modport slave (
    output start, abort, hold, valid_out_conv2,
    input  rd_en, rd_addr, layer_valid_in, out_row, out_col, out_last,
           busy, done, err
  );
endinterface

// File: rtl/conv2_seq.sv
// conv2_seq: frame sequencer for the second conv layer. Streams the source
// pool map out of memory in row-major order, delays the read strobe by the
// memory latency to form the layer's valid_in, and tracks the output-pixel
// coordinate from the layer's output strobes.
// Optional feature: define CONV2_SEQ_WDT_EN to add a DRAIN-phase watchdog
// that raises a sticky err and forces frame completion.
module conv2_seq #(
  parameter int WIDTH      = 12,
  parameter int HEIGHT     = 12,
  parameter int KSIZE      = 5,
  parameter int RD_LAT     = 1,
  parameter int WDT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  conv2_seq_if.master io
);
  localparam int OUT_W = WIDTH - KSIZE + 1;
  localparam int OUT_H = HEIGHT - KSIZE + 1;
  localparam int NPIX  = OUT_W * OUT_H;
  localparam int NRD   = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(NPIX + 1);

  generate
    if (RD_LAT < 1 || RD_LAT > 4 || NRD > 256 || OUT_W > 8 || OUT_H > 8 ||
        WDT_CYCLES < 2) begin : g_cfg_check
      $error("conv2_seq: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, FIN} state_t;

  state_t            state;
  logic [7:0]        rd_addr_q;
  logic [2:0]        row_q;
  logic [2:0]        col_q;
  logic [CNT_W-1:0]  pix_cnt;
  logic [RD_LAT-1:0] lat_sr;
  logic              done_q;
  logic              issue;
  logic              last_rd;
  logic              accept;
  logic              last_pix;
`ifdef CONV2_SEQ_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0]  wdt_cnt;
  logic              err_q;
`endif

  // Per-cycle decode: read issue, final read, strobe acceptance, final pixel
  always_comb begin
    issue    = (state == FEED) && !io.hold && !io.abort;
    last_rd  = issue && (rd_addr_q == 8'(NRD - 1));
    accept   = ((state == FEED) || (state == DRAIN)) && io.valid_out_conv2 && !io.abort;
    last_pix = accept && (pix_cnt == CNT_W'(NPIX - 1));
  end

  // Read-latency pipe: reads already issued keep flowing under hold; abort flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_sr <= '0;
    end else if (io.abort) begin
      lat_sr <= '0;
    end else begin
      lat_sr <= RD_LAT'({lat_sr, issue});
    end
  end

  // Frame FSM with address, coordinate, done and (optional) watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pix_cnt   <= '0;
      done_q    <= 1'b0;
`ifdef CONV2_SEQ_WDT_EN
      wdt_cnt   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (io.abort) begin
        state <= IDLE;
`ifdef CONV2_SEQ_WDT_EN
        wdt_cnt <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (io.start) begin
              state     <= FEED;
              rd_addr_q <= '0;
              row_q     <= '0;
              col_q     <= '0;
              pix_cnt   <= '0;
`ifdef CONV2_SEQ_WDT_EN
              err_q     <= 1'b0;
`endif
            end
          end
          FEED: begin
            if (issue) begin
              rd_addr_q <= rd_addr_q + 8'd1;
              if (last_rd) state <= DRAIN;
            end
          end
          DRAIN: begin
          end
          FIN: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase

        // Accepted strobe advances the coordinate; the final pixel overrides
        // any FEED->DRAIN move made in the same cycle.
        if (accept) begin
          pix_cnt <= pix_cnt + CNT_W'(1);
          if (col_q == 3'(OUT_W - 1)) begin
            col_q <= '0;
            row_q <= row_q + 3'd1;
          end else begin
            col_q <= col_q + 3'd1;
          end
          if (last_pix) begin
            state  <= FIN;
            done_q <= 1'b1;
          end
        end

`ifdef CONV2_SEQ_WDT_EN
        // Counts strobe-free DRAIN cycles; firing ends the frame with err set
        if (state != DRAIN || accept) begin
          wdt_cnt <= '0;
        end else if (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
          wdt_cnt <= '0;
          err_q   <= 1'b1;
          state   <= FIN;
          done_q  <= 1'b1;
        end else begin
          wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
`endif
      end
    end
  end

  assign io.rd_en          = issue;
  assign io.rd_addr        = rd_addr_q;
  assign io.layer_valid_in = lat_sr[RD_LAT-1];
  assign io.out_row        = row_q;
  assign io.out_col        = col_q;
  assign io.out_last       = last_pix;
  assign io.busy           = (state != IDLE);
  assign io.done           = done_q;
`ifdef CONV2_SEQ_WDT_EN
  assign io.err            = err_q;
`else
  assign io.err            = 1'b0;
`endif
endmodule

// File: tb/tb_conv2_seq.sv
// tb_conv2_seq: table-driven frames plus hand-written abort, reset, start
// corner cases. A small conv-layer model turns layer_valid_in into output
// strobes 4 cycles after each window-completing pixel; expected coordinates
// are queued when the pixel enters and compared when the strobe is driven.
`timescale 1ns/1ps
module tb_conv2_seq;
  localparam int W    = 12;
  localparam int H    = 12;
  localparam int K    = 5;
  localparam int OW   = W - K + 1;
  localparam int NRD  = W * H;
  localparam int NPIX = (W - K + 1) * (H - K + 1);
  localparam int SDLY = 4;
`ifdef CONV2_SEQ_WDT_EN
  localparam int WDT  = 16;
`else
  localparam int WDT  = 1024;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  conv2_seq_if io ();

  conv2_seq #(.WIDTH(W), .HEIGHT(H), .KSIZE(K), .RD_LAT(1), .WDT_CYCLES(WDT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  typedef struct {
    int due;
    int row;
    int col;
    bit last;
  } exp_t;

  typedef struct {
    string name;
    int    hold_at;
    int    hold_len;
    int    exp_reads;
    int    exp_strobes;
    int    exp_dones;
  } vec_t;

  exp_t sb[$];
  vec_t tv[4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_addr, reads, strobes, dones, pix_in;
  int hold_at = -1;
  int hold_left = 0;
  int last_strobe_cyc = 0;
  int done_cyc = 0;
  bit prev_rd_en = 1'b0;
  bit start_lvl = 1'b0;
  bit abort_next = 1'b0;
  bit drop_last = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic new_frame_model();
    exp_addr = 0;
    reads    = 0;
    strobes  = 0;
    dones    = 0;
    pix_in   = 0;
    sb.delete();
  endtask

  // One clock: drive after the rising edge, check on the falling edge
  task automatic step();
    exp_t e;
    bit   strobe;
    int   r, c;
    @(posedge clk);
    #1;
    cyc++;
    io.start = start_lvl;
    io.abort = abort_next;
    abort_next = 1'b0;
    if (hold_left > 0 && exp_addr == hold_at && io.busy && reads < NRD) begin
      io.hold = 1'b1;
      hold_left--;
    end else begin
      io.hold = 1'b0;
    end
    strobe = (sb.size() > 0) && (sb[0].due <= cyc);
    if (strobe) e = sb.pop_front();
    io.valid_out_conv2 = strobe;
    @(negedge clk);
    chk("layer_valid_in", io.layer_valid_in, prev_rd_en);
    if (io.hold) begin
      chk("rd_en_hold", io.rd_en, 0);
      chk("rd_addr_hold", io.rd_addr, exp_addr);
    end
    if (io.rd_en) begin
      chk("rd_addr", io.rd_addr, exp_addr);
      exp_addr++;
      reads++;
    end
    if (strobe) begin
      chk("out_row", io.out_row, e.row);
      chk("out_col", io.out_col, e.col);
      chk("out_last", io.out_last, e.last);
      strobes++;
      last_strobe_cyc = cyc;
    end else begin
      chk("out_last_quiet", io.out_last, 0);
    end
    if (io.done) begin
      chk("busy_in_fin", io.busy, 1);
      dones++;
      done_cyc = cyc;
    end
    if (io.layer_valid_in) begin
      r = pix_in / W;
      c = pix_in % W;
      if (r >= K - 1 && c >= K - 1) begin
        e.due  = cyc + SDLY;
        e.row  = r - (K - 1);
        e.col  = c - (K - 1);
        e.last = (r == H - 1) && (c == W - 1);
        if (!(drop_last && e.last)) sb.push_back(e);
      end
      pix_in++;
    end
    prev_rd_en = io.rd_en;
  endtask

  task automatic run_to_done(input string tag);
    int n;
    n = 0;
    while (dones == 0 && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, dones, 1);
  endtask

  task automatic kick();
    start_lvl = 1'b1;
    step();
    start_lvl = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tv[0] = '{"nohold",  -1,  0, NRD, NPIX, 1};
    tv[1] = '{"hold37",  37,  5, NRD, NPIX, 1};
    tv[2] = '{"hold0",    0,  3, NRD, NPIX, 1};
    tv[3] = '{"hold143", 143, 2, NRD, NPIX, 1};

    io.start = 1'b0;
    io.abort = 1'b0;
    io.hold = 1'b0;
    io.valid_out_conv2 = 1'b0;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_en", io.rd_en, 0);
    chk("rst_rd_addr", io.rd_addr, 0);
    chk("rst_lvi", io.layer_valid_in, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_done", io.done, 0);
    chk("rst_err", io.err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // no start: stays idle
    repeat (3) step();
    chk("idle_no_start", io.busy, 0);

    // table-driven full frames
    for (int i = 0; i < 4; i++) begin
      new_frame_model();
      hold_at   = tv[i].hold_at;
      hold_left = tv[i].hold_len;
      kick();
      chk({tv[i].name, "_start_idle"}, io.busy, 0);
      step();
      chk({tv[i].name, "_busy"}, io.busy, 1);
      run_to_done(tv[i].name);
      repeat (4) step();
      chk({tv[i].name, "_reads"}, reads, tv[i].exp_reads);
      chk({tv[i].name, "_strobes"}, strobes, tv[i].exp_strobes);
      chk({tv[i].name, "_dones"}, dones, tv[i].exp_dones);
      chk({tv[i].name, "_idle_after"}, io.busy, 0);
      chk({tv[i].name, "_hold_used"}, hold_left, 0);
    end
    hold_at = -1;

    // abort at address 90
    new_frame_model();
    kick();
    n = 0;
    while (exp_addr != 90 && n < 500) begin
      step();
      n++;
    end
    chk("abort_reached_90", exp_addr, 90);
    abort_next = 1'b1;
    step();
    chk("abort_rd_en", io.rd_en, 0);
    sb.delete();
    step();
    chk("abort_idle", io.busy, 0);
    chk("abort_lvi", io.layer_valid_in, 0);
    sb.delete();
    repeat (8) step();
    chk("abort_no_done", dones, 0);
    chk("abort_reads", reads, 90);

    // restart after abort: address and count from zero
    new_frame_model();
    kick();
    run_to_done("restart");
    repeat (3) step();
    chk("restart_reads", reads, NRD);
    chk("restart_strobes", strobes, NPIX);

    // start and abort in the same idle cycle
    start_lvl  = 1'b1;
    abort_next = 1'b1;
    step();
    start_lvl = 1'b0;
    step();
    chk("start_abort_idle", io.busy, 0);
    step();
    chk("start_abort_no_rd", io.rd_en, 0);

    // asynchronous reset in the middle of DRAIN
    new_frame_model();
    kick();
    n = 0;
    while (reads < NRD && n < 500) begin
      step();
      n++;
    end
    step();
    chk("drain_busy", io.busy, 1);
    chk("drain_no_rd", io.rd_en, 0);
    @(posedge clk);
    #3;
    io.valid_out_conv2 = 1'b0;
    io.hold = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_en", io.rd_en, 0);
    chk("arst_rd_addr", io.rd_addr, 0);
    chk("arst_lvi", io.layer_valid_in, 0);
    chk("arst_row", io.out_row, 0);
    chk("arst_col", io.out_col, 0);
    chk("arst_last", io.out_last, 0);
    chk("arst_busy", io.busy, 0);
    chk("arst_done", io.done, 0);
    chk("arst_err", io.err, 0);
    sb.delete();
    prev_rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // strobes while idle are ignored
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      io.valid_out_conv2 = 1'b1;
      @(negedge clk);
      chk("idle_strobe_last", io.out_last, 0);
      chk("idle_strobe_col", io.out_col, 0);
      chk("idle_strobe_busy", io.busy, 0);
    end
    @(posedge clk);
    #1;
    io.valid_out_conv2 = 1'b0;

    // start held high through FIN: one new frame, only after IDLE
    new_frame_model();
    start_lvl = 1'b1;
    step();
    run_to_done("held_start_f1");
    step();
    chk("held_start_idle", io.busy, 0);
    new_frame_model();
    step();
    chk("held_start_busy", io.busy, 1);
    chk("held_start_rd_en", io.rd_en, 1);
    start_lvl = 1'b0;
    run_to_done("held_start_f2");
    repeat (3) step();
    chk("held_start_reads", reads, NRD);
    chk("held_start_dones", dones, 1);
    chk("held_start_idle_end", io.busy, 0);

`ifdef CONV2_SEQ_WDT_EN
    // watchdog: final strobe withheld; 16 strobe-free DRAIN cycles, then FIN
    new_frame_model();
    drop_last = 1'b1;
    kick();
    run_to_done("wdt");
    chk("wdt_err", io.err, 1);
    chk("wdt_strobes", strobes, NPIX - 1);
    chk("wdt_quiet_cycles", done_cyc - last_strobe_cyc - 1, WDT);
    drop_last = 1'b0;
    repeat (2) step();
    chk("wdt_err_sticky", io.err, 1);
    new_frame_model();
    kick();
    step();
    chk("wdt_err_cleared", io.err, 0);
    run_to_done("wdt_recover");
    chk("wdt_recover_err", io.err, 0);
    repeat (2) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
